fetch_unit: RTL and testbench

Instruction fetch initiator that drives the read side of `mainmem` and delivers instruction words to decode. It holds the PC, presents it as the memory address in read mode, captures the combinational read data at each clock edge into a 2-entry buffer, and hands `{pc, insn}` pairs downstream over a valid/ready handshake. It sits between `mainmem` and the decode stage and supports branch redirects and fetch faults.

---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives mainmem reads from the PC and queues {pc, insn} pairs
// in a 2-entry FIFO for decode. Define FETCH_BOUNDS_CHECK_EN to fault on out-of-window fetches.
module fetch_unit #(
    parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn_out,
    output logic [31:0] insn_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] e0_pc_q, e0_pc_d, e0_insn_q, e0_insn_d;
    logic [31:0] e1_pc_q, e1_pc_d, e1_insn_q, e1_insn_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic pop;
    logic push;
    logic full;
    logic redirect_bad;

    // Unsigned offset compare also catches addresses below the window via wrap-around.
    function automatic logic out_of_window(input logic [31:0] a);
        return BoundsEn && ((a - STARTING_ADDR) >= MEM_DEPTH_BYTES);
    endfunction

    assign insn_valid = (cnt_q != 2'd0);
    assign pop        = insn_valid && insn_ready;
    assign full       = (cnt_q == 2'd2);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        e0_pc_d       = e0_pc_q;
        e0_insn_d     = e0_insn_q;
        e1_pc_d       = e1_pc_q;
        e1_insn_d     = e1_insn_q;
        cnt_d         = cnt_q;
        fault_addr_d  = fault_addr_q;
        fetch_count_d = fetch_count_q;
        push          = 1'b0;
        redirect_bad  = (redirect_target[1:0] != 2'b00) || out_of_window(redirect_target);

        // A pop always retires the head, even when a redirect flushes the rest.
        if (pop) begin
            e0_pc_d   = e1_pc_q;
            e0_insn_d = e1_insn_q;
            cnt_d     = cnt_q - 2'd1;
        end

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_valid) begin
                    if (redirect_bad) begin
                        state_d      = FAULT;
                        fault_addr_d = redirect_target;
                    end else begin
                        pc_d = redirect_target;
                    end
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    cnt_d = 2'd0;
                    if (redirect_bad) begin
                        state_d      = FAULT;
                        fault_addr_d = redirect_target;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (!full || pop) begin
                    if (out_of_window(pc_q)) begin
                        state_d      = FAULT;
                        fault_addr_d = pc_q;
                        cnt_d        = 2'd0;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            FAULT: begin
                cnt_d = 2'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase

        // Push lands in the first free slot after any same-cycle pop.
        if (push) begin
            if (cnt_d == 2'd0) begin
                e0_pc_d   = pc_q;
                e0_insn_d = mem_data_out;
            end else begin
                e1_pc_d   = pc_q;
                e1_insn_d = mem_data_out;
            end
            cnt_d         = cnt_d + 2'd1;
            fetch_count_d = fetch_count_q + 32'd1;
            pc_d          = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= STARTING_ADDR;
            e0_pc_q       <= 32'd0;
            e0_insn_q     <= 32'd0;
            e1_pc_q       <= 32'd0;
            e1_insn_q     <= 32'd0;
            cnt_q         <= 2'd0;
            fault_addr_q  <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            e0_pc_q       <= e0_pc_d;
            e0_insn_q     <= e0_insn_d;
            e1_pc_q       <= e1_pc_d;
            e1_insn_q     <= e1_insn_d;
            cnt_q         <= cnt_d;
            fault_addr_q  <= fault_addr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign mem_address    = pc_q;
    assign mem_read_write = 1'b0;
    assign mem_data_in    = 32'd0;
    assign insn_out       = e0_insn_q;
    assign insn_pc        = e0_pc_q;
    assign fault          = (state_q == FAULT);
    assign fault_addr     = fault_addr_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus an async-reset sequence.
// Memory word at address a is {a[15:0] ^ 16'hBEEF, a[15:0]}.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn_out;
    logic [31:0] insn_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    int total;
    int bad;

    fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_read_write  (mem_read_write),
        .mem_data_in     (mem_data_in),
        .mem_data_out    (mem_data_out),
        .insn_valid      (insn_valid),
        .insn_ready      (insn_ready),
        .insn_out        (insn_out),
        .insn_pc         (insn_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fault           (fault),
        .fault_addr      (fault_addr),
        .fetch_count     (fetch_count)
    );

    assign mem_data_out = {mem_address[15:0] ^ 16'hBEEF, mem_address[15:0]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rv;
        logic [31:0] tgt;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] einsn;
        logic [31:0] eaddr;
        logic [31:0] ecnt;
        bit          ef;
        logic [31:0] efa;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cycles;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        insn_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;

        //           rst rdy rv  tgt            ev  pc             insn           addr           cnt f  faddr
        // Streaming after reset release
        vecs.push_back('{1, 1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h01000000, 0, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h01000000, 0, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 32'h01000000, 32'hBEEF0000, 32'h01000004, 1, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 32'h01000004, 32'hBEEB0004, 32'h01000008, 2, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 32'h01000008, 32'hBEE70008, 32'h0100000C, 3, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 32'h0100000C, 32'hBEE3000C, 32'h01000010, 4, 0, 32'h0});
        // Backpressure: buffer fills, PC and head hold
        vecs.push_back('{1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h01000000, 0, 0, 32'h0});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h01000000, 0, 0, 32'h0});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 32'h01000000, 32'hBEEF0000, 32'h01000004, 1, 0, 32'h0});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 32'h01000000, 32'hBEEF0000, 32'h01000008, 2, 0, 32'h0});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 32'h01000000, 32'hBEEF0000, 32'h01000008, 2, 0, 32'h0});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 32'h01000000, 32'hBEEF0000, 32'h01000008, 2, 0, 32'h0});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 32'h01000000, 32'hBEEF0000, 32'h01000008, 2, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 32'h01000004, 32'hBEEB0004, 32'h0100000C, 3, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 32'h01000008, 32'hBEE70008, 32'h01000010, 4, 0, 32'h0});
        // Redirect with full buffer and same-cycle pop
        vecs.push_back('{0, 1, 1, 32'h01000040, 0, 32'h0,        32'h0,        32'h01000040, 4, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 32'h01000040, 32'hBEAF0040, 32'h01000044, 5, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 32'h01000044, 32'hBEAB0044, 32'h01000048, 6, 0, 32'h0});
        // Misaligned redirect faults; later redirects ignored
        vecs.push_back('{0, 1, 1, 32'h01000042, 0, 32'h0,        32'h0,        32'h01000048, 6, 1, 32'h01000042});
        vecs.push_back('{0, 1, 1, 32'h01000000, 0, 32'h0,        32'h0,        32'h01000048, 6, 1, 32'h01000042});
        vecs.push_back('{0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h01000048, 6, 1, 32'h01000042});
        // Window edge: redirect from IDLE to the last word
        vecs.push_back('{1, 1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h01000000, 0, 0, 32'h0});
        vecs.push_back('{0, 1, 1, 32'h010FFFFC, 0, 32'h0,        32'h0,        32'h010FFFFC, 0, 0, 32'h0});
        vecs.push_back('{0, 1, 0, 32'h0,        1, 32'h010FFFFC, 32'h4113FFFC, 32'h01100000, 1, 0, 32'h0});
`ifdef FETCH_BOUNDS_CHECK_EN
        vecs.push_back('{0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h01100000, 1, 1, 32'h01100000});
`else
        vecs.push_back('{0, 1, 0, 32'h0,        1, 32'h01100000, 32'hBEEF0000, 32'h01100004, 2, 0, 32'h0});
`endif
        // Set up one buffered entry for the async reset sequence
        vecs.push_back('{1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h01000000, 0, 0, 32'h0});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h01000000, 0, 0, 32'h0});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 32'h01000000, 32'hBEEF0000, 32'h01000004, 1, 0, 32'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset           = vecs[i].rst;
            insn_ready      = vecs[i].rdy;
            redirect_valid  = vecs[i].rv;
            redirect_target = vecs[i].tgt;
            @(posedge clock);
            #1;
            check($sformatf("r%0d valid", i), {31'd0, insn_valid}, {31'd0, vecs[i].ev});
            check($sformatf("r%0d mem_address", i), mem_address, vecs[i].eaddr);
            check($sformatf("r%0d fetch_count", i), fetch_count, vecs[i].ecnt);
            check($sformatf("r%0d fault", i), {31'd0, fault}, {31'd0, vecs[i].ef});
            check($sformatf("r%0d fault_addr", i), fault_addr, vecs[i].efa);
            if (vecs[i].ev || vecs[i].rst) begin
                check($sformatf("r%0d insn_pc", i), insn_pc, vecs[i].epc);
                check($sformatf("r%0d insn_out", i), insn_out, vecs[i].einsn);
            end
            if (vecs[i].rst) begin
                check($sformatf("r%0d mem_read_write", i), {31'd0, mem_read_write}, 32'd0);
                check($sformatf("r%0d mem_data_in", i), mem_data_in, 32'd0);
            end
        end

        // Asynchronous reset between edges discards the buffered entry at once
        @(negedge clock);
        redirect_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async valid", {31'd0, insn_valid}, 32'd0);
        check("async mem_address", mem_address, 32'h01000000);
        check("async fetch_count", fetch_count, 32'd0);
        check("async insn_out", insn_out, 32'd0);

        @(negedge clock);
        reset      = 1'b0;
        insn_ready = 1'b1;
        cycles = 0;
        while (!insn_valid && cycles < 10) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        check("restart edges to valid", cycles, 32'd2);
        check("restart insn_pc", insn_pc, 32'h01000000);
        check("restart insn_out", insn_out, 32'hBEEF0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
